toggle_pulse_rx: RTL

TOGGLE_PULSE_RX -- requirements
Module: toggle_pulse_rx

---
 rtl/toggle_pkg.sv | 13 +
 rtl/toggle_dff.sv | 17 +
 rtl/toggle_sync.sv | 28 ++
 rtl/toggle_pulse_rx.sv | 119 +++++++++++
 4 files changed

// File: rtl/toggle_pkg.sv
// Shared types and default sizing for the toggle-pulse receiver.
package toggle_pkg;

  localparam int unsigned SyncStagesDef = 2;
  localparam int unsigned CntWDef       = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    ACK  = 2'd2
  } state_e;

endpackage

// File: rtl/toggle_dff.sv
// Single D flop with synchronous active-high reset to 0; the building block of the synchronizer.
module toggle_dff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_o <= 1'b0;
    end else begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/toggle_sync.sv
// Multi-stage synchronizer for the asynchronous request toggle line.
module toggle_sync
  import toggle_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SyncStagesDef
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES:0] chain;

  assign chain[0] = d_i;

  for (genvar i = 0; i < SYNC_STAGES; i++) begin : g_stage
    toggle_dff u_dff (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (chain[i]),
      .q_o   (chain[i+1])
    );
  end

  assign q_o = chain[SYNC_STAGES];

endmodule

// File: rtl/toggle_pulse_rx.sv
// Receiver side of a toggle handshake: detects Tog level changes, counts them, holds one
// event (plus a one-deep queue) until Take, and returns each accepted event on AckTog.
module toggle_pulse_rx
  import toggle_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SyncStagesDef,
  parameter int unsigned CNT_W       = CntWDef
) (
  input  logic             Clk,
  input  logic             rst,
  input  logic             Tog,
  input  logic             Take,
  output logic             Pulse,
  output logic             Pend,
  output logic             AckTog,
  output logic [CNT_W-1:0] Cnt,
  output logic             Ovr
);

  logic tog_sync;
  logic tog_prev_q;
  logic edge_det;

  state_e state_q, state_d;

  logic             qd_q, qd_d;
  logic             ovr_q, ovr_d;
  logic             ack_tog_q, ack_tog_d;
  logic             pulse_q;
  logic             pend_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  toggle_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i (Clk),
    .rst_i (rst),
    .d_i   (Tog),
    .q_o   (tog_sync)
  );

  assign edge_det = tog_sync ^ tog_prev_q;

  // State register
  always_ff @(posedge Clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (edge_det) state_d = PEND;
      PEND:    if (Take) state_d = ACK;
      ACK:     state_d = (qd_q || edge_det) ? PEND : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Queue, overrun, counter and acknowledge next-state
  always_comb begin
    qd_d      = qd_q;
    ovr_d     = ovr_q;
    ack_tog_d = ack_tog_q;
    cnt_d     = edge_det ? cnt_q + CNT_W'(1) : cnt_q;
    case (state_q)
      PEND: begin
        if (edge_det) begin
          // With Take the current event leaves, so the new one only overruns a full queue.
          if (!qd_q) begin
            qd_d = 1'b1;
          end else if (!Take) begin
            ovr_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end
      end
      ACK: begin
        qd_d = 1'b0;
        if (edge_det && qd_q) ovr_d = 1'b1;
      end
      default: ;
    endcase
    if (state_q != ACK && state_d == ACK) ack_tog_d = ~ack_tog_q;
  end

  // Registered outputs and datapath state
  always_ff @(posedge Clk) begin
    if (rst) begin
      tog_prev_q <= 1'b0;
      qd_q       <= 1'b0;
      ovr_q      <= 1'b0;
      ack_tog_q  <= 1'b0;
      pulse_q    <= 1'b0;
      pend_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      tog_prev_q <= tog_sync;
      qd_q       <= qd_d;
      ovr_q      <= ovr_d;
      ack_tog_q  <= ack_tog_d;
      pulse_q    <= edge_det;
      pend_q     <= (state_d == PEND);
      cnt_q      <= cnt_d;
    end
  end

  assign Pulse  = pulse_q;
  assign Pend   = pend_q;
  assign AckTog = ack_tog_q;
  assign Cnt    = cnt_q;
  assign Ovr    = ovr_q;

endmodule
